// File: rtl/tge_txs_snap_ctrl.sv
// Purpose : gbe1 TX snapshot capture controller - arm, wait for trigger, write a 2^ADDR_WIDTH burst to BRAM.
// Latency : one cycle from a qualifying sample to its BRAM write; one cycle from state/count change to status_out.
// Backpres: none; samples offered while not capturing, or without qualification, are dropped.
//
// Ports:
//   user_clk, user_rst          clock, synchronous active-high reset
//   ctrl_in[0]=arm, [1]=sw_trig_mode, [2]=force_we; upper bits unused
//   trig_in                     external trigger, level sampled
//   din / din_valid             TX sample and qualifier
//   bram_addr/bram_din/bram_we  BRAM write port
//   status_out                  {done, capturing, armed, 0..., count}
module tge_txs_snap_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    input  logic [31:0]           ctrl_in,
    input  logic                  trig_in,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_we,
    output logic [31:0]           status_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t                state;
    logic   [ADDR_WIDTH:0] count;
    logic                  arm_q;
    logic                  arm_rise;
    logic                  qual;
    logic                  trig_hit;
    logic                  wr_en;
    logic                  ctrl_unused;

    // Upper control bits are reserved by the software register map.
    assign ctrl_unused = ^ctrl_in[31:3];

    assign arm_rise = ctrl_in[0] & ~arm_q;
    assign qual     = din_valid | ctrl_in[2];
    assign trig_hit = ctrl_in[1] | trig_in;

    // An arm edge always wins: the sample in that cycle is discarded even
    // if a trigger is present.
    always_comb begin
        wr_en = 1'b0;
        if (!arm_rise) begin
            case (state)
                ARMED:   wr_en = trig_hit & qual;
                CAPTURE: wr_en = qual;
                default: wr_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            // arm_q starts high so an arm bit already set at reset release
            // is not mistaken for a fresh software edge.
            arm_q      <= 1'b1;
            state      <= IDLE;
            count      <= '0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_din   <= '0;
            status_out <= '0;
        end else begin
            arm_q   <= ctrl_in[0];
            bram_we <= wr_en;

            // Status reflects the state/count as they stood before this edge.
            status_out <= {state == DONE, state == CAPTURE, state == ARMED,
                           {(28 - ADDR_WIDTH){1'b0}}, count};

            if (wr_en) begin
                bram_addr <= count[ADDR_WIDTH-1:0];
                bram_din  <= din;
                count     <= count + 1'b1;
            end

            if (arm_rise) begin
                state <= ARMED;
                count <= '0;
            end else begin
                case (state)
                    ARMED: begin
                        if (trig_hit) begin
                            state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        // Last address written: stop here, no wrap.
                        if (wr_en && count == LAST_ADDR) begin
                            state <= DONE;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tge_txs_snap_ctrl.sv
// Purpose : self-checking bench for tge_txs_snap_ctrl (ADDR_WIDTH=4) - vector table, directed corners, random vs reference model.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpres: not applicable.
module tb_tge_txs_snap_ctrl;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int DEPTH = 1 << AW;

    logic          user_clk;
    logic          user_rst;
    logic [31:0]   ctrl_in;
    logic          trig_in;
    logic [DW-1:0] din;
    logic          din_valid;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          bram_we;
    logic [31:0]   status_out;

    tge_txs_snap_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .user_clk   (user_clk),
        .user_rst   (user_rst),
        .ctrl_in    (ctrl_in),
        .trig_in    (trig_in),
        .din        (din),
        .din_valid  (din_valid),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_we    (bram_we),
        .status_out (status_out)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: phase 0 = idle, 1 = waiting for trigger,
    // 2 = filling, 3 = full. n = words captured since the last arm.
    int          m_phase;
    int          m_n;
    bit          m_arm_prev;
    bit          m_we;
    int          m_addr;
    logic [63:0] m_din;
    logic [31:0] m_status;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input logic [31:0] c, input logic t, input logic [63:0] d,
                              input logic v, input logic r);
        bit rise, hit, q, wr;
        if (r) begin
            m_arm_prev = 1'b1;
            m_phase    = 0;
            m_n        = 0;
            m_we       = 1'b0;
            m_addr     = 0;
            m_din      = '0;
            m_status   = '0;
        end else begin
            m_status = (m_phase == 3 ? 32'h8000_0000 : 32'h0) |
                       (m_phase == 2 ? 32'h4000_0000 : 32'h0) |
                       (m_phase == 1 ? 32'h2000_0000 : 32'h0) | 32'(m_n);
            rise = c[0] && !m_arm_prev;
            hit  = c[1] || t;
            q    = v || c[2];
            wr   = 1'b0;
            if (rise) begin
                m_phase = 1;
                m_n     = 0;
            end else if (m_phase == 1 && hit) begin
                m_phase = 2;
                wr      = q;
            end else if (m_phase == 2) begin
                wr = q;
            end
            m_we = wr;
            if (wr) begin
                m_addr = m_n;
                m_din  = d;
                m_n++;
                if (m_n == DEPTH) m_phase = 3;
            end
            m_arm_prev = c[0];
        end
    endtask

    // Drive one cycle of inputs, clock it, and compare against the model.
    task automatic step(input logic [31:0] c, input logic t, input logic [63:0] d,
                        input logic v, input logic r);
        ctrl_in   = c;
        trig_in   = t;
        din       = d;
        din_valid = v;
        user_rst  = r;
        @(posedge user_clk);
        #1;
        cyc++;
        model_edge(c, t, d, v, r);
        chk("model_we", {63'd0, bram_we}, {63'd0, m_we});
        if (m_we) begin
            chk("model_addr", {60'd0, bram_addr}, 64'(m_addr));
            chk("model_din", bram_din, m_din);
        end
        chk("model_status", {32'd0, status_out}, {32'd0, m_status});
    endtask

    typedef struct {
        logic [31:0] ctrl;
        logic        trig;
        logic [63:0] d;
        logic        v;
        logic        we;
        logic [3:0]  addr;
        logic [63:0] dout;
        logic [31:0] st;
    } vec_t;

    vec_t tbl[22];

    initial begin
        logic [31:0] rc;
        // Software-trigger capture after reset release with arm already high.
        tbl[0] = '{32'h1, 1'b0, 64'h0, 1'b1, 1'b0, 4'h0, 64'h0, 32'h0};
        tbl[1] = '{32'h1, 1'b1, 64'h0, 1'b1, 1'b0, 4'h0, 64'h0, 32'h0};
        tbl[2] = '{32'h0, 1'b0, 64'h0, 1'b1, 1'b0, 4'h0, 64'h0, 32'h0};
        tbl[3] = '{32'h3, 1'b0, 64'h0, 1'b1, 1'b0, 4'h0, 64'h0, 32'h0};
        for (int k = 4; k < 20; k++) begin
            tbl[k] = '{32'h3, 1'b0, 64'(k - 4), 1'b1, 1'b1, 4'(k - 4), 64'(k - 4),
                       (k == 4) ? 32'h2000_0000 : (32'h4000_0000 | 32'(k - 4))};
        end
        tbl[20] = '{32'h3, 1'b0, 64'h55, 1'b1, 1'b0, 4'h0, 64'h0, 32'h8000_0010};
        tbl[21] = '{32'h3, 1'b0, 64'h55, 1'b1, 1'b0, 4'h0, 64'h0, 32'h8000_0010};

        m_arm_prev = 1'b1; m_phase = 0; m_n = 0; m_we = 1'b0;
        m_addr = 0; m_din = '0; m_status = '0;

        // Reset held three cycles with arm high.
        for (int i = 0; i < 3; i++) begin
            step(32'h1, 1'b1, 64'hFFFF, 1'b1, 1'b1);
            chk("rst_we", {63'd0, bram_we}, 64'd0);
            chk("rst_addr", {60'd0, bram_addr}, 64'd0);
            chk("rst_din", bram_din, 64'd0);
            chk("rst_status", {32'd0, status_out}, 64'd0);
        end

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].ctrl, tbl[i].trig, tbl[i].d, tbl[i].v, 1'b0);
            chk("tbl_we", {63'd0, bram_we}, {63'd0, tbl[i].we});
            if (tbl[i].we) begin
                chk("tbl_addr", {60'd0, bram_addr}, {60'd0, tbl[i].addr});
                chk("tbl_din", bram_din, tbl[i].dout);
            end
            chk("tbl_status", {32'd0, status_out}, {32'd0, tbl[i].st});
        end

        // External trigger after a long wait.
        step(32'h0, 1'b0, 64'h0, 1'b1, 1'b0);
        step(32'h1, 1'b0, 64'h0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(32'h1, 1'b0, 64'(i), 1'b1, 1'b0);
            chk("ext_wait_armed", {63'd0, status_out[29]}, 64'd1);
            chk("ext_wait_no_we", {63'd0, bram_we}, 64'd0);
        end
        step(32'h1, 1'b1, 64'hAA, 1'b1, 1'b0);
        chk("ext_first_we", {63'd0, bram_we}, 64'd1);
        chk("ext_first_addr", {60'd0, bram_addr}, 64'd0);
        chk("ext_first_din", bram_din, 64'hAA);
        for (int i = 1; i < DEPTH; i++) step(32'h1, 1'b0, 64'(100 + i), 1'b1, 1'b0);
        step(32'h1, 1'b1, 64'h0, 1'b1, 1'b0);
        chk("ext_done_status", {32'd0, status_out}, 64'h8000_0010);
        chk("ext_done_no_we", {63'd0, bram_we}, 64'd0);

        // Valid gaps without force_we.
        step(32'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        step(32'h3, 1'b0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 36; i++) step(32'h3, 1'b0, 64'(200 + i), (i % 2) == 0, 1'b0);
        chk("gap_done_status", {32'd0, status_out}, 64'h8000_0010);

        // Same pattern with force_we: every cycle written.
        step(32'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        step(32'h7, 1'b0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(32'h7, 1'b0, 64'(300 + i), (i % 2) == 0, 1'b0);
            chk("force_we", {63'd0, bram_we}, 64'd1);
            chk("force_addr", {60'd0, bram_addr}, 64'(i));
        end
        step(32'h7, 1'b0, 64'h0, 1'b0, 1'b0);
        chk("force_done_status", {32'd0, status_out}, 64'h8000_0010);

        // Re-arm after seven writes.
        step(32'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        step(32'h3, 1'b0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(32'h3, 1'b0, 64'(400 + i), 1'b1, 1'b0);
        step(32'h2, 1'b0, 64'h0, 1'b0, 1'b0);
        step(32'h3, 1'b1, 64'h77, 1'b1, 1'b0);
        chk("rearm_no_we", {63'd0, bram_we}, 64'd0);
        step(32'h3, 1'b0, 64'h88, 1'b1, 1'b0);
        chk("rearm_we", {63'd0, bram_we}, 64'd1);
        chk("rearm_addr0", {60'd0, bram_addr}, 64'd0);
        chk("rearm_din", bram_din, 64'h88);
        chk("rearm_status", {32'd0, status_out}, 64'h2000_0000);
        for (int i = 0; i < 20; i++) step(32'h3, 1'b0, 64'(500 + i), 1'b1, 1'b0);

        // Reset in the middle of a capture.
        step(32'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        step(32'h3, 1'b0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(32'h3, 1'b0, 64'(600 + i), 1'b1, 1'b0);
        step(32'h3, 1'b0, 64'h0, 1'b1, 1'b1);
        chk("midrst_we", {63'd0, bram_we}, 64'd0);
        chk("midrst_status", {32'd0, status_out}, 64'd0);
        step(32'h3, 1'b0, 64'h0, 1'b1, 1'b0);
        step(32'h3, 1'b1, 64'h0, 1'b1, 1'b0);
        chk("midrst_no_rearm", {32'd0, status_out}, 64'd0);
        step(32'h0, 1'b0, 64'h0, 1'b1, 1'b0);
        step(32'h3, 1'b0, 64'h0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) step(32'h3, 1'b0, 64'(700 + i), 1'b1, 1'b0);
        chk("midrst_full_status", {32'd0, status_out}, 64'h8000_0010);

        // Random traffic against the model.
        rc = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] rd;
            if ($urandom_range(29, 0) == 0) rc[0] = ~rc[0];
            if ($urandom_range(59, 0) == 0) rc[1] = ~rc[1];
            if ($urandom_range(59, 0) == 0) rc[2] = ~rc[2];
            rc[31:3] = 29'($urandom);
            rd = {$urandom, $urandom};
            step(rc, $urandom_range(19, 0) == 0, rd, $urandom_range(3, 0) != 0,
                 $urandom_range(499, 0) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
